// File: rtl/coherence_bus_ctrl.sv
// Two-cache snooping coherence bus controller in front of a single-port RAM.
// Blocks are two words long; every transaction is word0 then word1.
module coherence_bus_ctrl (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate
);

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [2:0] {IDLE, WB0, WB1, SNOOP, C2C0, C2C1, RD0, RD1} state_t;

  state_t     state_q, state_d;
  logic       r_q, r_d;
  logic       ptr_q, ptr_d;
  logic       s;
  logic [1:0] req;
  logic       win;
  logic       acc;

  assign s   = ~r_q;
  assign req = cctrans | dWEN | dREN;
  // On a tie the pointer decides; otherwise whichever cache is asking.
  assign win = (req[0] & req[1]) ? ptr_q : req[1];
  assign acc = (ramstate == ACCESS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      r_q     <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          r_d = win;
          if (cctrans[win])      state_d = SNOOP;
          else if (dWEN[win])    state_d = WB0;
          else                   state_d = RD0;
        end
      end
      WB0:  if (acc) state_d = WB1;
      WB1:  if (acc) begin state_d = IDLE; ptr_d = s; end
      SNOOP: begin
        if (cctrans[s]) state_d = ccwrite[s] ? C2C0 : RD0;
      end
      C2C0: if (acc) state_d = C2C1;
      C2C1: if (acc) begin state_d = IDLE; ptr_d = s; end
      RD0:  if (acc) state_d = RD1;
      RD1:  if (acc) begin state_d = IDLE; ptr_d = s; end
      default: state_d = IDLE;
    endcase
  end

  // RD states show the snoop only when the requester asked for a bus transaction.
  always_comb begin
    dwait       = 2'b11;
    dload       = '0;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    unique case (state_q)
      IDLE: ;
      WB0, WB1: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[r_q];
        ramstore = dstore[r_q];
        if (acc) dwait[r_q] = 1'b0;
      end
      SNOOP: begin
        ccwait[s]      = 1'b1;
        ccsnoopaddr[s] = daddr[r_q];
        ccinv[s]       = ccwrite[r_q];
      end
      C2C0, C2C1: begin
        ccwait[s]      = 1'b1;
        ccsnoopaddr[s] = daddr[r_q];
        ccinv[s]       = ccwrite[r_q];
        dload[r_q]     = dstore[s];
        ramWEN         = 1'b1;
        ramaddr        = daddr[s];
        ramstore       = dstore[s];
        if (acc) dwait = 2'b00;
      end
      RD0, RD1: begin
        ramREN     = 1'b1;
        ramaddr    = daddr[r_q];
        dload[r_q] = ramload;
        if (cctrans[r_q]) begin
          ccwait[s]      = 1'b1;
          ccsnoopaddr[s] = daddr[r_q];
          ccinv[s]       = ccwrite[r_q];
        end
        if (acc) dwait[r_q] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: a per-cycle vector table plus
// hand-written sequences for arbitration alternation and a slow snooper.
module tb_coherence_bus_ctrl;

  localparam logic [1:0] RS_F = 2'd0, RS_B = 2'd1, RS_A = 2'd2, RS_E = 2'd3;

  logic             CLK, RST;
  logic [1:0]       dREN, dWEN, cctrans, ccwrite;
  logic [1:0][31:0] daddr, dstore;
  logic [1:0]       dwait, ccwait, ccinv;
  logic [1:0][31:0] dload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  ren, wen, trans, ccw, rs;
    logic [31:0] a0, a1, s0, s1, rload;
    logic [1:0]  eDwait, eCcwait, eCcinv;
    logic        eRen, eWen;
    logic [31:0] eRamaddr, eRamstore, eLoad0, eLoad1, eSnp0, eSnp1;
  } vec_t;

  vec_t vecs[$];

  coherence_bus_ctrl dut (
    .CLK(CLK), .RST(RST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite),
    .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    RST       = v.rst;
    dREN      = v.ren;
    dWEN      = v.wen;
    cctrans   = v.trans;
    ccwrite   = v.ccw;
    ramstate  = v.rs;
    daddr[0]  = v.a0;
    daddr[1]  = v.a1;
    dstore[0] = v.s0;
    dstore[1] = v.s1;
    ramload   = v.rload;
  endtask

  task automatic checkVector(input vec_t v);
    checkOutput({v.name, ".dwait"},    dwait,          v.eDwait);
    checkOutput({v.name, ".ccwait"},   ccwait,         v.eCcwait);
    checkOutput({v.name, ".ccinv"},    ccinv,          v.eCcinv);
    checkOutput({v.name, ".ramREN"},   ramREN,         v.eRen);
    checkOutput({v.name, ".ramWEN"},   ramWEN,         v.eWen);
    checkOutput({v.name, ".ramaddr"},  ramaddr,        v.eRamaddr);
    checkOutput({v.name, ".ramstore"}, ramstore,       v.eRamstore);
    checkOutput({v.name, ".dload0"},   dload[0],       v.eLoad0);
    checkOutput({v.name, ".dload1"},   dload[1],       v.eLoad1);
    checkOutput({v.name, ".snoop0"},   ccsnoopaddr[0], v.eSnp0);
    checkOutput({v.name, ".snoop1"},   ccsnoopaddr[1], v.eSnp1);
  endtask

  task automatic clearInputs();
    dREN = 2'b00; dWEN = 2'b00; cctrans = 2'b00; ccwrite = 2'b00;
    daddr = '0; dstore = '0; ramload = '0; ramstate = RS_F;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // name, rst, ren, wen, trans, ccw, rs, a0, a1, s0, s1, rload, eDwait, eCcwait, eCcinv, eRen, eWen, eRamaddr, eRamstore, eLoad0, eLoad1, eSnp0, eSnp1
    vecs.push_back('{"idle_reset",      1'b0, 2'b00, 2'b00, 2'b00, 2'b00, RS_F, 32'h0,   32'h0,   32'h0,    32'h0,  32'h0,        2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,    32'h0,   32'h0});
    vecs.push_back('{"r023_idle",       1'b0, 2'b01, 2'b00, 2'b01, 2'b00, RS_F, 32'h100, 32'h0,   32'h0,    32'h0,  32'h0,        2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,    32'h0,   32'h0});
    vecs.push_back('{"r023_snoop_wait", 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, RS_A, 32'h100, 32'h0,   32'h0,    32'h0,  32'h0,        2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,    32'h0,   32'h100});
    vecs.push_back('{"r023_snoop_ack",  1'b0, 2'b01, 2'b00, 2'b11, 2'b00, RS_F, 32'h100, 32'h0,   32'h0,    32'h0,  32'h0,        2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,    32'h0,   32'h100});
    vecs.push_back('{"r023_rd0_busy",   1'b0, 2'b01, 2'b00, 2'b01, 2'b00, RS_B, 32'h100, 32'h0,   32'h0,    32'h0,  32'h11,       2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0,        32'h11,       32'h0,    32'h0,   32'h100});
    vecs.push_back('{"r023_rd0_access", 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, RS_A, 32'h100, 32'h0,   32'h0,    32'h0,  32'hAAAA0000, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 32'h100, 32'h0,        32'hAAAA0000, 32'h0,    32'h0,   32'h100});
    vecs.push_back('{"r023_rd1_access", 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, RS_A, 32'h101, 32'h0,   32'h0,    32'h0,  32'hAAAA0001, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 32'h101, 32'h0,        32'hAAAA0001, 32'h0,    32'h0,   32'h101});
    vecs.push_back('{"r023_done",       1'b0, 2'b00, 2'b00, 2'b00, 2'b00, RS_F, 32'h0,   32'h0,   32'h0,    32'h0,  32'h0,        2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,    32'h0,   32'h0});
    vecs.push_back('{"r024_idle",       1'b0, 2'b10, 2'b00, 2'b10, 2'b10, RS_F, 32'h0,   32'h200, 32'h0,    32'h0,  32'h0,        2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,    32'h0,   32'h0});
    vecs.push_back('{"r024_snoop_ack",  1'b0, 2'b10, 2'b00, 2'b11, 2'b11, RS_F, 32'h200, 32'h200, 32'hDEAD, 32'h0,  32'h0,        2'b11, 2'b01, 2'b01, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,    32'h200, 32'h0});
    vecs.push_back('{"r024_c2c0_busy",  1'b0, 2'b10, 2'b00, 2'b11, 2'b11, RS_B, 32'h200, 32'h200, 32'hDEAD, 32'h0,  32'h0,        2'b11, 2'b01, 2'b01, 1'b0, 1'b1, 32'h200, 32'hDEAD,     32'h0,        32'hDEAD, 32'h200, 32'h0});
    vecs.push_back('{"r024_c2c0_acc",   1'b0, 2'b10, 2'b00, 2'b11, 2'b11, RS_A, 32'h200, 32'h200, 32'hDEAD, 32'h0,  32'h0,        2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 32'h200, 32'hDEAD,     32'h0,        32'hDEAD, 32'h200, 32'h0});
    vecs.push_back('{"r024_c2c1_acc",   1'b0, 2'b10, 2'b00, 2'b11, 2'b11, RS_A, 32'h201, 32'h201, 32'hBEEF, 32'h0,  32'h0,        2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 32'h201, 32'hBEEF,     32'h0,        32'hBEEF, 32'h201, 32'h0});
    vecs.push_back('{"r024_done",       1'b0, 2'b00, 2'b00, 2'b00, 2'b00, RS_F, 32'h0,   32'h0,   32'h0,    32'h0,  32'h0,        2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,    32'h0,   32'h0});
    vecs.push_back('{"r026_idle",       1'b0, 2'b00, 2'b01, 2'b00, 2'b00, RS_F, 32'h300, 32'h0,   32'h12345678, 32'h0, 32'h0,     2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,    32'h0,   32'h0});
    vecs.push_back('{"r026_wb0_busy1",  1'b0, 2'b00, 2'b01, 2'b00, 2'b00, RS_B, 32'h300, 32'h0,   32'h12345678, 32'h0, 32'h0,     2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 32'h300, 32'h12345678, 32'h0,        32'h0,    32'h0,   32'h0});
    vecs.push_back('{"r026_wb0_busy2",  1'b0, 2'b00, 2'b01, 2'b00, 2'b00, RS_B, 32'h300, 32'h0,   32'h12345678, 32'h0, 32'h0,     2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 32'h300, 32'h12345678, 32'h0,        32'h0,    32'h0,   32'h0});
    vecs.push_back('{"r026_wb0_error",  1'b0, 2'b00, 2'b01, 2'b00, 2'b00, RS_E, 32'h300, 32'h0,   32'h12345678, 32'h0, 32'h0,     2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 32'h300, 32'h12345678, 32'h0,        32'h0,    32'h0,   32'h0});
    vecs.push_back('{"r026_wb0_acc",    1'b0, 2'b00, 2'b01, 2'b00, 2'b00, RS_A, 32'h300, 32'h0,   32'h12345678, 32'h0, 32'h0,     2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 32'h300, 32'h12345678, 32'h0,        32'h0,    32'h0,   32'h0});
    vecs.push_back('{"r026_wb1_acc",    1'b0, 2'b00, 2'b01, 2'b00, 2'b00, RS_A, 32'h301, 32'h0,   32'h9ABCDEF0, 32'h0, 32'h0,     2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 32'h301, 32'h9ABCDEF0, 32'h0,        32'h0,    32'h0,   32'h0});
    vecs.push_back('{"r026_done",       1'b0, 2'b00, 2'b00, 2'b00, 2'b00, RS_F, 32'h0,   32'h0,   32'h0,    32'h0,  32'h0,        2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,    32'h0,   32'h0});
    vecs.push_back('{"r027_idle",       1'b0, 2'b01, 2'b00, 2'b01, 2'b01, RS_F, 32'h400, 32'h0,   32'h0,    32'h0,  32'h0,        2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,    32'h0,   32'h0});
    vecs.push_back('{"r027_snoop_ack",  1'b0, 2'b01, 2'b00, 2'b11, 2'b11, RS_F, 32'h400, 32'h400, 32'h0,    32'h55, 32'h0,        2'b11, 2'b10, 2'b10, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,    32'h0,   32'h400});
    vecs.push_back('{"r027_c2c0_rst",   1'b1, 2'b01, 2'b00, 2'b11, 2'b11, RS_B, 32'h400, 32'h400, 32'h0,    32'h55, 32'h0,        2'b11, 2'b10, 2'b10, 1'b0, 1'b1, 32'h400, 32'h55,       32'h55,       32'h0,    32'h0,   32'h400});
    vecs.push_back('{"r027_after_rst",  1'b0, 2'b00, 2'b00, 2'b00, 2'b00, RS_F, 32'h0,   32'h0,   32'h0,    32'h0,  32'h0,        2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0,    32'h0,   32'h0});

    RST = 1'b1;
    clearInputs();
    repeat (3) @(posedge CLK);

    foreach (vecs[i]) begin
      @(negedge CLK);
      applyStimulus(vecs[i]);
      #1;
      checkVector(vecs[i]);
    end

    // Both caches keep requesting reads: grants must alternate 0, 1, 0.
    begin
      int w;
      @(negedge CLK);
      clearInputs();
      dREN = 2'b11; daddr[0] = 32'h500; daddr[1] = 32'h600; ramstate = RS_A; ramload = 32'h77;
      for (int k = 0; k < 3; k++) begin
        w = k % 2;
        if (k != 0) @(negedge CLK);
        #1;
        checkOutput($sformatf("r025_idle%0d.dwait", k), dwait, 2'b11);
        for (int wd = 0; wd < 2; wd++) begin
          @(negedge CLK);
          #1;
          checkOutput($sformatf("r025_grant%0d_w%0d.dwait", k, wd), dwait, (w == 1) ? 2'b01 : 2'b10);
          checkOutput($sformatf("r025_grant%0d_w%0d.ramaddr", k, wd), ramaddr, (w == 1) ? 32'h600 : 32'h500);
        end
      end
    end

    // Slow snooper: SNOOP must hold for five cycles with the RAM untouched.
    @(negedge CLK);
    clearInputs();
    dREN = 2'b10; cctrans = 2'b10; daddr[1] = 32'h700; ramstate = RS_A; ramload = 32'h88;
    #1;
    checkOutput("r028_idle.dwait", dwait, 2'b11);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #1;
      checkOutput($sformatf("r028_wait%0d.ccwait", i), ccwait, 2'b01);
      checkOutput($sformatf("r028_wait%0d.dwait", i), dwait, 2'b11);
      checkOutput($sformatf("r028_wait%0d.ram", i), {ramREN, ramWEN}, 2'b00);
      checkOutput($sformatf("r028_wait%0d.snoop0", i), ccsnoopaddr[0], 32'h700);
    end
    @(negedge CLK);
    cctrans = 2'b11;
    #1;
    checkOutput("r028_ack.ccwait", ccwait, 2'b01);
    checkOutput("r028_ack.ramREN", ramREN, 1'b0);
    @(negedge CLK);
    cctrans = 2'b10;
    #1;
    checkOutput("r028_rd0.ramREN", ramREN, 1'b1);
    checkOutput("r028_rd0.dwait", dwait, 2'b01);
    checkOutput("r028_rd0.dload1", dload[1], 32'h88);
    @(negedge CLK);
    #1;
    checkOutput("r028_rd1.dwait", dwait, 2'b01);
    @(negedge CLK);
    clearInputs();
    #1;
    checkOutput("r028_done.dwait", dwait, 2'b11);
    checkOutput("r028_done.ccwait", ccwait, 2'b00);
    checkOutput("r028_done.ramREN", ramREN, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/coherence_bus_ctrl.md
COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

Interface
- REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK in 1, rising-edge clock; RST in 1, synchronous active-high reset.
- REQ-002 The block SHALL have these cache-side ports, one bit or word per cache index 0..1:
  - dREN in 2: cache read request (miss fill).
  - dWEN in 2: cache write request; eviction write-back when cctrans[i]=0.
  - daddr in 2x32: word address driven by cache i.
  - dstore in 2x32: write or supply data from cache i.
  - cctrans in 2: as requester, bus transaction request; as snooper, snoop acknowledge.
  - ccwrite in 2: as requester, 1=BusRdX, 0=BusRd; as snooper, 1=holds Modified copy and supplies data.
  - dwait out 2: 1 stalls cache i.
  - dload out 2x32: read data to cache i.
  - ccwait out 2: snoop in progress at cache i.
  - ccinv out 2: invalidate snooped block at cache i.
  - ccsnoopaddr out 2x32: snoop address to cache i.
- REQ-003 The block SHALL have these RAM-side ports:
  - ramREN out 1; ramWEN out 1.
  - ramaddr out 32; ramstore out 32.
  - ramload in 32.
  - ramstate in 2 (ramstate_t: FREE, BUSY, ACCESS, ERROR).

Function
- REQ-004 Blocks SHALL be two words; each transaction SHALL perform exactly two RAM accesses (word0, then word1); caches sequence the word offset on daddr.
- REQ-005 Request from cache i: req[i] = cctrans[i] | dWEN[i] | dREN[i]; a requester SHALL hold all request signals stable until its final dwait low.
- REQ-006 Arbitration SHALL be round-robin with a 1-bit priority pointer, reset 0; on simultaneous req the pointer index wins; after any completed transaction the pointer SHALL point to the non-granted cache.
- REQ-007 The states SHALL be IDLE, WB0, WB1, SNOOP, C2C0, C2C1, RD0 and RD1; the granted index r and the snooper s = ~r are registered on leaving IDLE.
- REQ-008 IDLE transitions:
  - no req -> stay in IDLE.
  - winner dWEN & ~cctrans -> WB0.
  - winner cctrans -> SNOOP.
  - winner dREN & ~cctrans -> RD0, with no snoop.
- REQ-009 WB0/WB1 SHALL drive ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r], and advance on ramstate==ACCESS; WB1 SHALL return to IDLE.
- REQ-010 SNOOP SHALL drive ccwait[s]=1, ccsnoopaddr[s]=daddr[r], ccinv[s]=ccwrite[r], with no RAM request. It SHALL wait while cctrans[s]=0. On cctrans[s]=1 it SHALL go to C2C0 if ccwrite[s]=1, else to RD0.
- REQ-011 ccwait[s], ccsnoopaddr[s] and ccinv[s] SHALL stay asserted through C2C0/C2C1, and SHALL drop on return to IDLE.
- REQ-012 C2C0/C2C1 (cache-to-cache with memory update) SHALL drive dload[r]=dstore[s], ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s]. On ramstate==ACCESS both dwait[r] and dwait[s] SHALL be 0 for that cycle and the state SHALL advance; C2C1 SHALL return to IDLE.
- REQ-013 RD0/RD1 SHALL drive ramREN=1, ramaddr=daddr[r], dload[r]=ramload, and ccwait[s]/ccinv[s] as in SNOOP. On ACCESS, dwait[r]=0 and the state SHALL advance; RD1 SHALL return to IDLE.
- REQ-014 dwait[i] SHALL be 1 in every cycle not named in REQ-009/012/013. In WB states dwait[r]=0 on ACCESS.
- REQ-015 ramREN and ramWEN SHALL never both be 1. In IDLE and SNOOP both SHALL be 0.
- REQ-016 ramstate BUSY or FREE SHALL hold the current state.
- REQ-017 ramstate ERROR SHALL be treated as BUSY (retry).
- REQ-018 Outputs SHALL be combinational from state, r and inputs. Only state, r and the pointer are registered.
- REQ-019 A req[s] arriving during r's transaction SHALL NOT be serviced until IDLE is re-entered.

Reset
- REQ-020 While RST=1 at a rising edge, the next state SHALL be IDLE, the pointer 0 and r 0.
- REQ-021 In IDLE the outputs SHALL be: dwait=2'b11, ccwait=0, ccinv=0, ccsnoopaddr=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, dload=0.
- REQ-022 Reset asserted mid-transaction SHALL abandon it with no further RAM access.

Verification
- REQ-023 Cache0 dREN+cctrans, ccwrite=0, daddr=0x100; cache1 acks cctrans=1, ccwrite=0 -> ccwait[1]=1, ccsnoopaddr[1]=0x100, ccinv[1]=0; two ramREN reads; dload[0]=ramload; two dwait[0] low pulses.
- REQ-024 Cache1 BusRdX (ccwrite=1) at 0x200; cache0 supplies (ccwrite=1, dstore=0xDEAD/0xBEEF) -> ccinv[0]=1; ramWEN writes 0xDEAD then 0xBEEF; dload[1] matches; dwait both low on each ACCESS.
- REQ-025 Both caches request in the same cycle from reset -> cache0 served first, then cache1. Repeat with both requesting -> cache0 served again only after cache1 (alternation).
- REQ-026 Cache0 write-back (dWEN=1, cctrans=0, 0x300) with ramstate BUSY for 3 cycles -> ramWEN held, state stalls, no ccwait; completes after 2 ACCESS.
- REQ-027 RST asserted in C2C0 -> next cycle IDLE values per REQ-021; ramWEN=0.
- REQ-028 Snooper delays cctrans 5 cycles -> SNOOP held, no RAM activity, dwait=2'b11.
